// File: rtl/seg_mux_driver.sv
// seg_mux_driver: 8-digit multiplexed 7-segment driver. Blanks all anodes for
// BLANK_CYCLES after every digit change and snapshots display data on entry to
// digit 0 so a frame never tears.
module seg_mux_driver #(
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  digit_sel,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  input  logic        lz_suppress,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [7:0] CntInit = 8'(BLANK_CYCLES - 1);

  typedef enum logic {StBlank, StDrive} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sel_q;
  logic [2:0]  cur_q, cur_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] sh_value_q, sh_value_d;
  logic [7:0]  sh_dp_q, sh_dp_d;
  logic [7:0]  sh_en_q, sh_en_d;
  logic        sh_lz_q, sh_lz_d;
  logic [7:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        fs_q, fs_d;

  logic        change;
  logic [31:0] upper;
  logic [6:0]  seg_hex;
  logic        show;

  assign change = (digit_sel != sel_q);

  // Nibbles cur..7 shifted down; bits [3:0] are the current digit.
  assign upper = sh_value_q >> {cur_q, 2'b00};

  // Active-low hex decode of the current nibble, segment order {a,b,c,d,e,f,g}.
  always_comb begin
    seg_hex = 7'h7F;
    case (upper[3:0])
      4'h0: seg_hex = 7'h01;
      4'h1: seg_hex = 7'h4F;
      4'h2: seg_hex = 7'h12;
      4'h3: seg_hex = 7'h06;
      4'h4: seg_hex = 7'h4C;
      4'h5: seg_hex = 7'h24;
      4'h6: seg_hex = 7'h20;
      4'h7: seg_hex = 7'h0F;
      4'h8: seg_hex = 7'h00;
      4'h9: seg_hex = 7'h04;
      4'hA: seg_hex = 7'h08;
      4'hB: seg_hex = 7'h60;
      4'hC: seg_hex = 7'h31;
      4'hD: seg_hex = 7'h42;
      4'hE: seg_hex = 7'h30;
      4'hF: seg_hex = 7'h38;
      default: seg_hex = 7'h7F;
    endcase
  end

  // Digit visibility: enabled and not a suppressed leading zero (digit 0 never suppressed).
  always_comb begin
    show = sh_en_q[cur_q] & ~(sh_lz_q & (cur_q != 3'd0) & (upper == 32'h0));
  end

  // Next-state: a digit change always wins and restarts the blanking gap.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    sh_value_d = sh_value_q;
    sh_dp_d    = sh_dp_q;
    sh_en_d    = sh_en_q;
    sh_lz_d    = sh_lz_q;
    anode_d    = anode_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    fs_d       = 1'b0;

    if (change) begin
      state_d = StBlank;
      cnt_d   = CntInit;
      cur_d   = digit_sel;
      anode_d = 8'hFF;
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      if (digit_sel == 3'd0) begin
        sh_value_d = value;
        sh_dp_d    = dp_mask;
        sh_en_d    = digit_en;
        sh_lz_d    = lz_suppress;
        fs_d       = 1'b1;
      end
    end else begin
      case (state_q)
        StBlank: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = StDrive;
            if (show) begin
              anode_d = ~(8'b1 << cur_q);
              seg_d   = seg_hex;
              dp_d    = ~sh_dp_q[cur_q];
            end else begin
              anode_d = 8'hFF;
              seg_d   = 7'h7F;
              dp_d    = 1'b1;
            end
          end
        end
        StDrive: begin
          // Outputs hold until the next change.
        end
        default: state_d = StBlank;
      endcase
    end
  end

  // State and output registers; reset darkens the display immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StBlank;
      sel_q      <= 3'd0;
      cur_q      <= 3'd0;
      cnt_q      <= CntInit;
      sh_value_q <= 32'h0;
      sh_dp_q    <= 8'h0;
      sh_en_q    <= 8'h0;
      sh_lz_q    <= 1'b0;
      anode_q    <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= digit_sel;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      sh_value_q <= sh_value_d;
      sh_dp_q    <= sh_dp_d;
      sh_en_q    <= sh_en_d;
      sh_lz_q    <= sh_lz_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign anode       = anode_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Bench for seg_mux_driver: three instances (BLANK_CYCLES 4, 1, 16) share one
// stimulus; a queue holds the expected digit image for each scan step.
module tb_seg_mux_driver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [2:0]  digit_sel;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  digit_en;
  logic        lz_suppress;

  logic [7:0] an4, an1, an16;
  logic [6:0] sg4, sg1, sg16;
  logic       dp4, dp1, dp16;
  logic       fs4, fs1, fs16;

  seg_mux_driver #(.BLANK_CYCLES(4)) dut4 (
    .clock(clock), .reset(reset), .digit_sel(digit_sel), .value(value),
    .dp_mask(dp_mask), .digit_en(digit_en), .lz_suppress(lz_suppress),
    .anode(an4), .seg(sg4), .dp(dp4), .frame_start(fs4)
  );
  seg_mux_driver #(.BLANK_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .digit_sel(digit_sel), .value(value),
    .dp_mask(dp_mask), .digit_en(digit_en), .lz_suppress(lz_suppress),
    .anode(an1), .seg(sg1), .dp(dp1), .frame_start(fs1)
  );
  seg_mux_driver dut16 (
    .clock(clock), .reset(reset), .digit_sel(digit_sel), .value(value),
    .dp_mask(dp_mask), .digit_en(digit_en), .lz_suppress(lz_suppress),
    .anode(an16), .seg(sg16), .dp(dp16), .frame_start(fs16)
  );

  localparam logic [15:0] Dark = {8'hFF, 7'h7F, 1'b1};

  int n_checks = 0;
  int n_errors = 0;

  // Bench copy of the frame snapshot.
  logic [31:0] sh_value;
  logic [7:0]  sh_dp, sh_en;
  logic        sh_lz;
  logic [15:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    return tbl[n];
  endfunction

  // Expected {anode, seg, dp} for digit i from the bench snapshot.
  function automatic logic [15:0] disp(input logic [2:0] i);
    logic zero;
    zero = 1'b1;
    for (int j = 0; j < 8; j++)
      if (j >= int'(i) && sh_value[4*j +: 4] != 4'h0) zero = 1'b0;
    if (!sh_en[i] || (sh_lz && i != 3'd0 && zero)) return Dark;
    return {~(8'd1 << i), hex7(sh_value[4*i +: 4]), ~sh_dp[i]};
  endfunction

  // All three instances against their blank length at cycle N+k.
  task automatic check_cycle(input int k, input logic [2:0] sel, input logic [15:0] ent);
    logic fs_exp;
    fs_exp = (k == 1) && (sel == 3'd0);
    check_eq($sformatf("b4 sel%0d k%0d", sel, k), {15'd0, an4, sg4, dp4, fs4},
             {15'd0, (k <= 4) ? Dark : ent, fs_exp});
    check_eq($sformatf("b1 sel%0d k%0d", sel, k), {15'd0, an1, sg1, dp1, fs1},
             {15'd0, (k <= 1) ? Dark : ent, fs_exp});
    check_eq($sformatf("b16 sel%0d k%0d", sel, k), {15'd0, an16, sg16, dp16, fs16},
             {15'd0, (k <= 16) ? Dark : ent, fs_exp});
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, " b4"}, {15'd0, an4, sg4, dp4, fs4}, {15'd0, Dark, 1'b0});
    check_eq({tag, " b1"}, {15'd0, an1, sg1, dp1, fs1}, {15'd0, Dark, 1'b0});
    check_eq({tag, " b16"}, {15'd0, an16, sg16, dp16, fs16}, {15'd0, Dark, 1'b0});
  endtask

  // Drive a new digit index (always different from the current one) and check hold cycles.
  task automatic step(input logic [2:0] sel, input int hold);
    logic [15:0] ent;
    ent = Dark;
    @(posedge clock);
    #1;
    digit_sel = sel;
    if (sel == 3'd0) begin
      sh_value = value;
      sh_dp    = dp_mask;
      sh_en    = digit_en;
      sh_lz    = lz_suppress;
    end
    sb.push_back(disp(sel));
    @(negedge clock);  // cycle N: change is seen at the next edge
    for (int k = 1; k <= hold; k++) begin
      @(negedge clock);
      if (k == 2) ent = sb.pop_front();
      check_cycle(k, sel, ent);
    end
    if (hold < 2) ent = sb.pop_front();
  endtask

  task automatic frame(input int hold);
    for (int s = 1; s <= 7; s++) step(3'(s), hold);
    step(3'd0, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    digit_sel   = 3'd0;
    value       = 32'h0;
    dp_mask     = 8'h0;
    digit_en    = 8'h0;
    lz_suppress = 1'b0;
    sh_value    = 32'h0;
    sh_dp       = 8'h0;
    sh_en       = 8'h0;
    sh_lz       = 1'b0;
    repeat (2) @(negedge clock);
    check_dark("in reset");

    // Released with digit_sel parked at 0: stays dark, no frame pulse.
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_dark($sformatf("idle c%0d", i));
    end

    // Basic decode; wrap 7->0 captures the snapshot.
    value    = 32'h1234ABCD;
    digit_en = 8'hFF;
    frame(18);
    step(3'd4, 18);

    // Mid-frame input change only shows after the next capture.
    step(3'd1, 18);
    step(3'd2, 18);
    step(3'd3, 18);
    value   = 32'hFFFFFFFF;
    dp_mask = 8'h20;
    for (int s = 4; s <= 7; s++) step(3'(s), 18);
    step(3'd0, 18);
    step(3'd5, 18);
    step(3'd6, 18);

    // Leading-zero suppression.
    value       = 32'h00000050;
    dp_mask     = 8'h00;
    lz_suppress = 1'b1;
    step(3'd0, 18);
    for (int s = 7; s >= 0; s--) step(3'(s), 18);
    value = 32'h0;
    frame(18);
    step(3'd1, 18);
    step(3'd0, 18);
    digit_en = 8'hFE;
    step(3'd1, 18);
    step(3'd0, 18);

    // Change during blank restarts the gap for the new digit.
    digit_en    = 8'hFF;
    lz_suppress = 1'b0;
    value       = 32'h89ABCDEF;
    step(3'd1, 18);
    step(3'd0, 18);
    step(3'd3, 1);
    step(3'd5, 18);

    // Asynchronous reset in DRIVE darkens before any clock edge.
    #2;
    reset     = 1'b1;
    digit_sel = 3'd0;
    #1;
    check_dark("async reset");
    sh_value = 32'h0;
    sh_dp    = 8'h0;
    sh_en    = 8'h0;
    sh_lz    = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_dark($sformatf("post reset c%0d", i));
    end
    step(3'd1, 18);
    step(3'd0, 18);
    step(3'd2, 18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
Downstream consumer of the 3-bit rotating digit index from the cathode scan counter. Drives an 8-digit multiplexed 7-segment display:
- one-hot active-low anode
- active-low segments and decimal point
- hex decoding, leading-zero suppression and per-digit enable

Inserts a blanking gap on every digit change to prevent ghosting. Captures display data once per frame so a frame never tears.

Parameters:
BLANK_CYCLES, 16, number of clock cycles all anodes are off after each digit_sel change; legal range 1..255; 8-bit internal counter.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
digit_sel  input  3  current digit index from the cathode scan counter; changes at most once per scan step
value  input  32  eight hex nibbles; digit i = value[4i+3:4i]
dp_mask  input  8  bit i set = decimal point on for digit i
digit_en  input  8  bit i set = digit i may light
lz_suppress  input  1  1 = blank leading zero digits
anode  output  8  active-low one-hot digit enable; anode[i] low = digit i lit
seg  output  7  active-low segments, seg[6:0] = {a,b,c,d,e,f,g}
dp  output  1  active-low decimal point
frame_start  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
Reset (asynchronous, immediate):
- anode=8'hFF, seg=7'h7F, dp=1, frame_start=0.
- sel_q=0, cur=0, state=BLANK, cnt=BLANK_CYCLES-1.
- Shadow registers (value, dp_mask, digit_en, lz_suppress) = 0, so the display stays dark until the first capture.

Change detect:
- sel_q registers digit_sel every cycle.
- change = (digit_sel != sel_q).

On change, in any state, at that edge:
- state<=BLANK, cnt<=BLANK_CYCLES-1, cur<=digit_sel.
- anode<=FF, seg<=7F, dp<=1.
- If digit_sel==0: load shadow registers from the inputs and set frame_start<=1.
- Otherwise frame_start<=0.
- frame_start is 0 in every cycle where it is not set by this rule.

BLANK state:
- If cnt!=0: cnt decrements; outputs stay off.
- If cnt==0 with no change: go to DRIVE and register the outputs for digit cur (rules below).

DRIVE state:
- Outputs hold until the next change.

Timing:
- Change seen in cycle N → outputs off in cycles N+1..N+BLANK_CYCLES → digit driven from cycle N+BLANK_CYCLES+1.

Digit visibility (cur = i) — digit i is shown iff all of the following hold:
- shadow_en[i] = 1
- NOT (shadow_lz AND i != 0 AND nibbles i..7 are all zero)

Outputs when shown:
- anode = ~(8'b1<<i)
- seg = hex decode of nibble i
- dp = ~shadow_dp[i]

Not shown: anode=FF, seg=7F, dp=1. Digit 0 is never zero-suppressed.

Hex decode (active-low {a..g}):
- 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F
- 8:00 9:04 A:08 b:60 C:31 d:42 E:30 F:38

Boundary conditions:
- A change during BLANK restarts the blank with the new cur.
- Input changes to value, dp_mask, digit_en or lz_suppress mid-frame have no effect until the next entry to digit 0.
- Wrap 7→0 is a normal change and triggers a capture.
- Reset mid-DRIVE blanks the outputs immediately, without waiting for a clock edge.

Test Plan:
1. Reset asserted, then released with digit_sel held at 0 → anode=FF, seg=7F, dp=1, frame_start=0 indefinitely.
2. value=32'h1234ABCD, digit_en=FF, dp_mask=00, lz=0; step digit_sel 1..7 then 0 → frame_start high exactly one cycle after the 7→0 change edge; BLANK_CYCLES later anode=FE, seg=42. Next step to 4 → anode=EF, seg=4C.
3. BLANK_CYCLES=4, change detected in cycle N → anode=FF in cycles N+1..N+4; anode=driven value in cycle N+5. Repeat with BLANK_CYCLES=1 → 1 blank cycle.
4. Mid-frame, at digit 3, change value to 32'hFFFFFFFF → digits 4..7 keep the old nibbles; after the next 0 entry, digit 5 shows seg=38. Also set dp_mask[5]=1 → dp=0 on digit 5 only.
5. lz=1, value=32'h00000050 → digits 7..2 anode=FF; digit1 seg=24; digit0 seg=01. value=0 → only digit0 lit, seg=01. digit_en[0]=0 → fully dark.
6. Change during BLANK: second change at cnt=2 → blank restarts, new digit driven BLANK_CYCLES after the second change. Async reset pulse in DRIVE → anode=FF before the next clock edge.
